// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage PC unit.
package fetch_pkg;

    localparam int unsigned PC_WIDTH_DEF = 8;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StBubble,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch control bundle: redirect/hazard inputs, instruction-memory handshake and PC outputs.
interface fetch_pc_unit_if import fetch_pkg::*; #(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
);
    logic                stall;
    logic                halt;
    logic                branch_valid;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                jump_valid;
    logic [PC_WIDTH-1:0] jump_target;
    logic                if_ready;
    logic                if_valid;
    logic [PC_WIDTH-1:0] pc;
    logic                flush;
    logic                halted;

    modport master (
        input  stall,
        input  halt,
        input  branch_valid,
        input  branch_taken,
        input  branch_target,
        input  jump_valid,
        input  jump_target,
        input  if_ready,
        output if_valid,
        output pc,
        output flush,
        output halted
    );

    modport slave (
        output stall,
        output halt,
        output branch_valid,
        output branch_taken,
        output branch_target,
        output jump_valid,
        output jump_target,
        output if_ready,
        input  if_valid,
        input  pc,
        input  flush,
        input  halted
    );

endinterface

// File: rtl/next_pc_mux.sv
// Priority select of the next PC: jump, then taken branch, then sequential advance, else hold.
module next_pc_mux import fetch_pkg::*; #(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_valid,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                advance,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                redirect
);

    always_comb begin
        next_pc  = pc;
        redirect = 1'b0;
        if (jump_valid) begin
            next_pc  = jump_target;
            redirect = 1'b1;
        end else if (branch_valid && branch_taken) begin
            next_pc  = branch_target;
            redirect = 1'b1;
        end else if (advance) begin
            // Wraps modulo 2**PC_WIDTH by construction.
            next_pc = pc + PC_WIDTH'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: boot/fetch/bubble/halted control, PC register and decode flush pulse.
module fetch_pc_unit import fetch_pkg::*; #(
    parameter int unsigned          PC_WIDTH = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(RESET_PC_DEF),
    parameter int unsigned          PC_STEP  = 1
) (
    input logic              clk,
    input logic              rst_n,
    fetch_pc_unit_if.master  bus
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, mux_pc;
    logic                flush_q, if_valid_q, halted_q;
    logic                advance, redirect;

    assign advance = (state_q == StFetch) && if_valid_q && bus.if_ready && !bus.stall;

    next_pc_mux #(
        .PC_WIDTH (PC_WIDTH),
        .PC_STEP  (PC_STEP)
    ) u_next_pc_mux (
        .pc            (pc_q),
        .jump_valid    (bus.jump_valid),
        .jump_target   (bus.jump_target),
        .branch_valid  (bus.branch_valid),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .advance       (advance),
        .next_pc       (mux_pc),
        .redirect      (redirect)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StBoot, StFetch, StBubble: begin
                // Halt outranks any redirect and freezes the PC where it is.
                if (bus.halt) begin
                    state_d = StHalted;
                end else if (redirect) begin
                    state_d = StBubble;
                    pc_d    = mux_pc;
                end else begin
                    state_d = StFetch;
                    pc_d    = mux_pc;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            // Bubble is only ever entered through a redirect, so it doubles as the flush cue.
            flush_q    <= (state_d == StBubble);
            if_valid_q <= (state_d == StFetch);
            halted_q   <= (state_d == StHalted);
        end
    end

    assign bus.pc       = pc_q;
    assign bus.if_valid = if_valid_q;
    assign bus.flush    = flush_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, sequential fetch, redirects, holds, wrap, halt.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fetch_pc_unit_if #(.PC_WIDTH(8)) bus ();

    fetch_pc_unit #(
        .PC_WIDTH (8),
        .RESET_PC (8'h00),
        .PC_STEP  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e_pc, input logic e_valid,
                              input logic e_flush, input logic e_halted);
        chk({tag, ".pc"}, 32'(bus.pc), 32'(e_pc));
        chk({tag, ".if_valid"}, 32'(bus.if_valid), 32'(e_valid));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(e_flush));
        chk({tag, ".halted"}, 32'(bus.halted), 32'(e_halted));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        bus.halt          = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 8'h00;
        bus.jump_valid    = 1'b0;
        bus.jump_target   = 8'h00;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.stall    = 1'b0;
        bus.if_ready = 1'b1;
        clear_redirects();
        tick();
        tick();
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Release reset: one boot cycle, then one fetch per cycle.
        rst_n = 1'b1;
        tick(); expect_out("seq0", 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("seq1", 8'h01, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("seq2", 8'h02, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("seq3", 8'h03, 1'b1, 1'b0, 1'b0);

        bus.jump_valid = 1'b1; bus.jump_target = 8'h80;
        tick(); expect_out("jmp80", 8'h80, 1'b0, 1'b1, 1'b0);
        clear_redirects();
        tick(); expect_out("at80", 8'h80, 1'b1, 1'b0, 1'b0);

        bus.branch_valid = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 8'hB4;
        tick(); expect_out("brB4", 8'hB4, 1'b0, 1'b1, 1'b0);
        clear_redirects();
        tick(); expect_out("atB4", 8'hB4, 1'b1, 1'b0, 1'b0);

        // Jump beats a simultaneous taken branch.
        bus.jump_valid = 1'b1; bus.jump_target = 8'h10;
        bus.branch_valid = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 8'h83;
        tick(); expect_out("jmp_wins", 8'h10, 1'b0, 1'b1, 1'b0);
        // Second redirect while in the bubble.
        clear_redirects();
        bus.jump_valid = 1'b1; bus.jump_target = 8'h84;
        tick(); expect_out("b2b", 8'h84, 1'b0, 1'b1, 1'b0);
        clear_redirects();
        tick(); expect_out("at84", 8'h84, 1'b1, 1'b0, 1'b0);
        bus.branch_valid = 1'b1; bus.branch_taken = 1'b0; bus.branch_target = 8'hC0;
        tick(); expect_out("not_taken", 8'h85, 1'b1, 1'b0, 1'b0);
        clear_redirects();

        bus.jump_valid = 1'b1; bus.jump_target = 8'h8C;
        tick(); expect_out("jmp8C", 8'h8C, 1'b0, 1'b1, 1'b0);
        clear_redirects();
        tick(); expect_out("at8C", 8'h8C, 1'b1, 1'b0, 1'b0);
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("not_ready", 8'h8C, 1'b1, 1'b0, 1'b0);
        end
        bus.if_ready = 1'b1;
        bus.stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("stalled", 8'h8C, 1'b1, 1'b0, 1'b0);
        end
        bus.branch_valid = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 8'h20;
        tick(); expect_out("br_in_stall", 8'h20, 1'b0, 1'b1, 1'b0);
        clear_redirects();
        bus.stall = 1'b0;
        tick(); expect_out("at20", 8'h20, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("at21", 8'h21, 1'b1, 1'b0, 1'b0);

        // Wrap at the top of the PC range.
        bus.jump_valid = 1'b1; bus.jump_target = 8'hFF;
        tick(); expect_out("jmpFF", 8'hFF, 1'b0, 1'b1, 1'b0);
        clear_redirects();
        tick(); expect_out("atFF", 8'hFF, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("wrap", 8'h00, 1'b1, 1'b0, 1'b0);

        // Halt beats a simultaneous jump and is sticky.
        bus.halt = 1'b1; bus.jump_valid = 1'b1; bus.jump_target = 8'h55;
        tick(); expect_out("halt", 8'h00, 1'b0, 1'b0, 1'b1);
        bus.halt = 1'b0;
        bus.branch_valid = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 8'h66;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("halted_hold", 8'h00, 1'b0, 1'b0, 1'b1);
        end

        clear_redirects();
        rst_n = 1'b0;
        tick(); expect_out("reset2", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(); expect_out("refetch0", 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("refetch1", 8'h01, 1'b1, 1'b0, 1'b0);
        bus.jump_valid = 1'b1; bus.jump_target = 8'h40;
        tick(); expect_out("jmp40", 8'h40, 1'b0, 1'b1, 1'b0);
        // Reset during the bubble discards the pending redirect.
        bus.jump_target = 8'h99;
        rst_n = 1'b0;
        tick(); expect_out("reset_bubble", 8'h00, 1'b0, 1'b0, 1'b0);
        clear_redirects();
        rst_n = 1'b1;
        tick(); expect_out("after_reset", 8'h00, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
